// File: rtl/audio_mixer.sv
// audio_mixer: time-multiplexed stereo mixer with per-channel volume/pan, saturating
// frame accumulation and a first-order 1-bit sigma-delta DAC per side.
module audio_mixer #(
    parameter int CHANNELS = 8,
    parameter int DW       = 8,
    parameter int VW       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS*DW-1:0] ch,
    input  logic [CHANNELS*VW-1:0] vol,
    input  logic [CHANNELS*2-1:0]  pan,
    input  logic                   mute,
    output logic [DW-1:0]          sample_l,
    output logic [DW-1:0]          sample_r,
    output logic                   strobe,
    output logic [1:0]             audio
);
    localparam int SW = $clog2(CHANNELS);
    localparam int AW = DW + SW;
    localparam int PW = DW + VW + 1;
    localparam logic [AW-1:0] FULL = AW'((1 << DW) - 1);

    logic [SW-1:0] slot;
    logic [AW-1:0] acc_l, acc_r, sum_l, sum_r;
    logic [DW-1:0] cur, term;
    logic [VW-1:0] cur_vol;
    logic [1:0]    cur_pan;
    logic [PW-1:0] prod;
    logic [DW:0]   d_l, d_r;
    logic          last;

    always_comb begin
        cur     = ch[int'(slot)*DW +: DW];
        cur_vol = vol[int'(slot)*VW +: VW];
        cur_pan = pan[int'(slot)*2 +: 2];
        prod    = PW'(cur) * (PW'(cur_vol) + PW'(1));
        term    = DW'(prod >> VW);
        sum_l   = acc_l + (cur_pan[0] ? AW'(term) : '0);
        sum_r   = acc_r + (cur_pan[1] ? AW'(term) : '0);
        last    = slot == SW'(CHANNELS - 1);
    end

    // The last slot's term is folded in directly so the frame closes in one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot     <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            sample_l <= '0;
            sample_r <= '0;
            strobe   <= 1'b0;
            d_l      <= '0;
            d_r      <= '0;
        end else begin
            slot   <= last ? '0 : slot + SW'(1);
            strobe <= last;
            acc_l  <= last ? '0 : sum_l;
            acc_r  <= last ? '0 : sum_r;
            if (last) begin
                sample_l <= mute ? '0 : (sum_l > FULL ? '1 : sum_l[DW-1:0]);
                sample_r <= mute ? '0 : (sum_r > FULL ? '1 : sum_r[DW-1:0]);
            end
            d_l <= {1'b0, d_l[DW-1:0]} + {1'b0, sample_l};
            d_r <= {1'b0, d_r[DW-1:0]} + {1'b0, sample_r};
        end
    end

    assign audio = {d_r[DW], d_l[DW]};
endmodule
